// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in parallel-out receiver (far end of the parallel-to-serial link).
//   Samples one bit per qualified strobe, assembles WIDTH-bit words and
//   presents each completed word through a one-word holding register on a
//   valid/ready port. A word that completes while the holding register is
//   full and not being drained is dropped and raises a sticky overrun flag.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   serial_in    serial data bit
//   shift        bit strobe (sampled when mode_select=0)
//   mode_select  1 = receiver paused (shift ignored, partial word held)
//   clear        aborts the partial word and clears overrun
//   data_out     assembled word, stable while data_valid=1
//   data_valid   completed word available
//   data_ready   consumer accepts on data_valid && data_ready
//   busy         partial word in progress (bit_cnt != 0)
//   bit_cnt      bits received for the current word
//   overrun      sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serial_in,
    input  logic                     shift,
    input  logic                     mode_select,
    input  logic                     clear,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     busy,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     overrun
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic             capture;
    logic             complete;
    logic             load;
    logic             drop;

    // clear has priority over a same-cycle strobe, so it also blocks capture.
    assign capture  = shift && !mode_select && !clear;
    assign complete = capture && (bit_cnt == LAST_BIT);

    // Shift register contents including the bit being captured this edge;
    // on a completing edge this is the full word offered to the holding reg.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shift_nxt = {serial_in, shift_reg[WIDTH-1:1]};
        end else begin
            shift_nxt = {shift_reg[WIDTH-2:0], serial_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (capture) begin
            shift_reg <= shift_nxt;
            bit_cnt   <= complete ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Holding register FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding register FSM: next state. A completion on the same edge as a
    // transfer refills the register, so the FSM stays FULL without a gap.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    state_nxt = FULL;
                    load      = 1'b1;
                end
            end
            FULL: begin
                if (complete) begin
                    if (data_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (data_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (load) begin
            data_out <= shift_nxt;
        end
    end

    // clear and drop cannot coincide: clear suppresses completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (clear) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

    assign data_valid = (state == FULL);
    assign busy       = (bit_cnt != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//   Bench for sipo_deserializer. Two instances (LSB-first and MSB-first) share
//   all inputs. A behavioural model tracks received bits as an indexed list,
//   a pending-word flag and an overrun flag; a compare process checks both
//   instances against it every falling edge. Directed sequences pin the model
//   with literal values, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         shift;
    logic         mode_select;
    logic         clear;
    logic         data_ready;

    logic [W-1:0] dout_l, dout_m;
    logic         valid_l, valid_m;
    logic         busy_l, busy_m;
    logic [3:0]   cnt_l, cnt_m;
    logic         ovr_l, ovr_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift(shift),
        .mode_select(mode_select), .clear(clear), .data_out(dout_l),
        .data_valid(valid_l), .data_ready(data_ready), .busy(busy_l),
        .bit_cnt(cnt_l), .overrun(ovr_l)
    );

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift(shift),
        .mode_select(mode_select), .clear(clear), .data_out(dout_m),
        .data_valid(valid_m), .data_ready(data_ready), .busy(busy_m),
        .bit_cnt(cnt_m), .overrun(ovr_m)
    );

    // ---------------- behavioural model ----------------
    int           m_cnt;
    logic [W-1:0] m_bits;     // m_bits[i] = i-th received bit of current word
    logic         m_valid;
    logic [W-1:0] m_word_l;
    logic [W-1:0] m_word_m;
    logic         m_ovr;
    logic         m_live = 1'b0;

    always @(posedge clk) begin
        logic xfer;
        logic comp;
        if (rst) begin
            m_cnt    = 0;
            m_bits   = '0;
            m_valid  = 1'b0;
            m_word_l = '0;
            m_word_m = '0;
            m_ovr    = 1'b0;
        end else begin
            xfer = m_valid && data_ready;
            comp = 1'b0;
            if (clear) begin
                m_cnt  = 0;
                m_bits = '0;
                m_ovr  = 1'b0;
            end else if (shift && !mode_select) begin
                m_bits[m_cnt] = serial_in;
                m_cnt = m_cnt + 1;
                if (m_cnt == W) begin
                    comp  = 1'b1;
                    m_cnt = 0;
                end
            end
            if (xfer) m_valid = 1'b0;
            if (comp) begin
                if (!m_valid) begin
                    m_valid  = 1'b1;
                    m_word_l = m_bits;
                    for (int i = 0; i < W; i++) m_word_m[W-1-i] = m_bits[i];
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        m_live = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("valid_l", 32'(valid_l), 32'(m_valid));
            check("valid_m", 32'(valid_m), 32'(m_valid));
            check("ovr_l", 32'(ovr_l), 32'(m_ovr));
            check("ovr_m", 32'(ovr_m), 32'(m_ovr));
            check("cnt_l", 32'(cnt_l), 32'(m_cnt));
            check("cnt_m", 32'(cnt_m), 32'(m_cnt));
            check("busy_l", 32'(busy_l), 32'(m_cnt != 0));
            check("busy_m", 32'(busy_m), 32'(m_cnt != 0));
            check("dout_l", 32'(dout_l), 32'(m_word_l));
            check("dout_m", 32'(dout_m), 32'(m_word_m));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        shift = 1'b0; data_ready = rdy;
        tick();
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        serial_in = b; shift = 1'b1; data_ready = rdy;
        tick();
        shift = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++) send_bit(w[i], rdy);
    endtask

    initial begin
        logic [W-1:0] seq;
        rst = 1'b1; serial_in = 1'b0; shift = 1'b0; mode_select = 1'b0;
        clear = 1'b0; data_ready = 1'b0;
        tick(); tick();
        check("reset valid", 32'(valid_l), 32'd0);
        check("reset dout", 32'(dout_l), 32'd0);
        check("reset cnt", 32'(cnt_m), 32'd0);
        rst = 1'b0;
        idle(1'b0);

        // Basic LSB/MSB-first: bits 0,1,1,1,1,0,0,0
        seq = 8'b0001_1110;
        send_word(seq, 1'b1);
        check("basic valid", 32'(valid_l), 32'd1);
        check("basic lsb", 32'(dout_l), 32'h1E);
        check("basic msb", 32'(dout_m), 32'h78);
        check("model lsb", 32'(m_word_l), 32'h1E);
        idle(1'b1);
        check("basic one-cycle", 32'(valid_l), 32'd0);
        check("basic busy", 32'(busy_l), 32'd0);

        // Backpressure / overrun
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
        check("bp hold", 32'(dout_l), 32'hA5);
        check("bp ovr", 32'(ovr_l), 32'd1);
        idle(1'b1);
        check("bp drained", 32'(valid_l), 32'd0);
        check("bp ovr sticky", 32'(ovr_l), 32'd1);
        clear = 1'b1; idle(1'b0); clear = 1'b0;
        check("clear ovr", 32'(ovr_l), 32'd0);

        // Simultaneous accept and complete
        send_word(8'h11, 1'b0);
        seq = 8'h22;
        for (int i = 0; i < W - 1; i++) send_bit(seq[i], 1'b0);
        send_bit(seq[W-1], 1'b1);
        check("simul valid", 32'(valid_l), 32'd1);
        check("simul dout", 32'(dout_l), 32'h22);
        check("simul ovr", 32'(ovr_l), 32'd0);
        idle(1'b1);

        // Pause, clear, reset
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        mode_select = 1'b1;
        for (int i = 0; i < 5; i++) begin
            serial_in = 1'b1; shift = (i % 2 == 0); tick();
        end
        mode_select = 1'b0;
        check("pause cnt", 32'(cnt_l), 32'd3);
        clear = 1'b1; shift = 1'b1; tick(); clear = 1'b0; shift = 1'b0;
        check("clear cnt", 32'(cnt_l), 32'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst cnt", 32'(cnt_l), 32'd0);
        check("rst busy", 32'(busy_l), 32'd0);
        check("rst dout", 32'(dout_l), 32'd0);
        send_word(8'h5A, 1'b1);
        check("fresh word", 32'(dout_l), 32'h5A);
        check("fresh msb", 32'(dout_m), 32'h5A);
        idle(1'b1);

        // Randomized run
        for (int n = 0; n < 4000; n++) begin
            serial_in   = 1'($urandom_range(0, 1));
            shift       = ($urandom_range(0, 99) < 70);
            mode_select = ($urandom_range(0, 99) < 10);
            clear       = ($urandom_range(0, 99) < 3);
            rst         = ($urandom_range(0, 999) < 5);
            data_ready  = ($urandom_range(0, 99) < 40);
            tick();
        end
        rst = 1'b0; shift = 1'b0; clear = 1'b0; mode_select = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
